// File: rtl/patch_pkg.sv
// Shared types and default geometry for the query patch Wishbone master.
package patch_pkg;

  localparam int          DEF_DATA_WIDTH     = 11;
  localparam int          DEF_PATCH_SIZE     = 5;
  localparam int          DEF_ADDR_WIDTH     = 9;
  localparam logic [31:0] DEF_BASE_ADDR      = 32'h200;
  localparam int          DEF_TIMEOUT_CYCLES = 64;

  typedef logic [DEF_DATA_WIDTH*DEF_PATCH_SIZE-1:0] patch_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    RESP
  } state_t;

endpackage

// File: rtl/wb_patch_addr_gen.sv
// Word address of one patch element: BASE_ADDR + patch*PATCH_SIZE + element,
// 32-bit unsigned, wrapping. Purely combinational; the parent registers it.
module wb_patch_addr_gen #(
  parameter int          ADDR_WIDTH = 9,
  parameter int          PATCH_SIZE = 5,
  parameter int          IDX_W      = 3,
  parameter logic [31:0] BASE_ADDR  = 32'h200
) (
  input  logic [ADDR_WIDTH-1:0] patch_addr,
  input  logic [IDX_W-1:0]      elem_idx,
  output logic [31:0]           wb_addr
);

  assign wb_addr = BASE_ADDR + (32'(patch_addr) * 32'(PATCH_SIZE)) + 32'(elem_idx);

endmodule

// File: rtl/wb_patch_master.sv
// Wishbone classic master that writes/reads one query patch as PATCH_SIZE
// single-beat cycles. Define WB_TIMEOUT_EN to build the ack watchdog.
module wb_patch_master
  import patch_pkg::*;
#(
  parameter int          DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int          PATCH_SIZE     = DEF_PATCH_SIZE,
  parameter int          ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [31:0] BASE_ADDR      = DEF_BASE_ADDR,
  parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH*PATCH_SIZE-1:0] req_patch,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH*PATCH_SIZE-1:0] rsp_patch,
  output logic                             rsp_err,
  output logic                             wbm_cyc_o,
  output logic                             wbm_stb_o,
  output logic                             wbm_we_o,
  output logic [3:0]                       wbm_sel_o,
  output logic [31:0]                      wbm_adr_o,
  output logic [31:0]                      wbm_dat_o,
  input  logic [31:0]                      wbm_dat_i,
  input  logic                             wbm_ack_i
);

  localparam int                PATCH_W  = DATA_WIDTH * PATCH_SIZE;
  localparam int                IDX_W    = (PATCH_SIZE > 1) ? $clog2(PATCH_SIZE) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PATCH_SIZE - 1);

  state_t               state_q, state_d;
  logic                 we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [PATCH_W-1:0]   patch_q;
  logic [IDX_W-1:0]     idx_q;

  logic                 accept, launch, beat_done, timeout, wd_expired;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [IDX_W-1:0]     gen_idx;
  logic [31:0]          gen_adr;
  logic [PATCH_W-1:0]   src_patch;
  logic [DATA_WIDTH-1:0] src_elem;
  logic                 we_sel;

  assign req_ready = (state_q == IDLE);

  // The next beat is launched either from the request itself (IDLE) or from
  // the latched request (GAP), so the bus registers load in the same edge.
  assign gen_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign gen_idx   = (state_q == IDLE) ? '0        : idx_q + 1'b1;
  assign src_patch = (state_q == IDLE) ? req_patch : patch_q;
  assign we_sel    = (state_q == IDLE) ? req_we    : we_q;
  assign src_elem  = src_patch[gen_idx*DATA_WIDTH +: DATA_WIDTH];

  wb_patch_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .PATCH_SIZE (PATCH_SIZE),
    .IDX_W      (IDX_W),
    .BASE_ADDR  (BASE_ADDR)
  ) u_addr_gen (
    .patch_addr (gen_addr),
    .elem_idx   (gen_idx),
    .wb_addr    (gen_adr)
  );

  always_comb begin
    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    state_d   = state_q;
    accept    = 1'b0;
    launch    = 1'b0;
    beat_done = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          launch  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (wbm_ack_i) begin
          beat_done = 1'b1;
          state_d   = (idx_q == LAST_IDX) ? RESP : GAP;
        end else if (wd_expired) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      GAP: begin
        launch  = 1'b1;
        state_d = ISSUE;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: patch storage is ordinary flops, so it is reset with the control state.
    if (!rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      patch_q   <= '0;
      idx_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_patch <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register update from pre-edge values.
      state_q   <= state_d;
      rsp_valid <= (state_q == RESP);

      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        // A read starts from the current response so a timed-out read keeps
        // the old contents of elements it never fetched.
        patch_q <= req_we ? req_patch : rsp_patch;
        idx_q   <= '0;
      end else if (state_q == GAP) begin
        idx_q <= idx_q + 1'b1;
      end

      if (beat_done && !we_q) begin
        patch_q[idx_q*DATA_WIDTH +: DATA_WIDTH] <= wbm_dat_i[DATA_WIDTH-1:0];
      end

      if (state_q == RESP && !we_q) begin
        rsp_patch <= patch_q;
      end

      if (launch) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= we_sel;
        wbm_sel_o <= 4'hF;
        wbm_adr_o <= gen_adr;
        wbm_dat_o <= 32'(src_elem);
      end else if (beat_done || timeout) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_sel_o <= '0;
      end
    end
  end

`ifdef WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  // The last unacknowledged ISSUE cycle is the TIMEOUT_CYCLES-th one.
  assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q    <= '0;
      err_q   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (launch) begin
        wd_q <= '0;
      end else if (state_q == ISSUE && !wbm_ack_i) begin
        wd_q <= wd_q + 1'b1;
      end
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
      rsp_err <= (state_q == RESP) && err_q;
    end
  end
`else
  logic timeout_cfg_unused;

  assign wd_expired         = 1'b0;
  assign rsp_err            = 1'b0;
  assign timeout_cfg_unused = (TIMEOUT_CYCLES > 0);
`endif

  generate
    if (DATA_WIDTH < 32) begin : g_dat_hi
      logic dat_hi_unused;
      assign dat_hi_unused = ^wbm_dat_i[31:DATA_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_wb_patch_master.sv
// Randomized self-checking bench for wb_patch_master: a bus-level slave memory
// and a per-beat expectation model derived from the address/latency rules.
module tb_wb_patch_master;
  import patch_pkg::*;

  localparam int          DW        = 11;
  localparam int          PS        = 5;
  localparam int          TO        = 8;
  localparam logic [31:0] MAIN_BASE = 32'h200;
  localparam logic [31:0] WRAP_BASE = 32'hFFFFFFFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [8:0]  req_addr;
  patch_t      req_patch;
  logic [31:0] dat_i;
  logic        ack;
  logic        use_wrap;

  logic        d_ready, d_rsp_valid, d_err, d_cyc, d_stb, d_we;
  logic [3:0]  d_sel;
  logic [31:0] d_adr, d_dat;
  patch_t      d_rsp_patch;
  logic        w_ready, w_rsp_valid, w_err, w_cyc, w_stb, w_we;
  logic [3:0]  w_sel;
  logic [31:0] w_adr, w_dat;
  patch_t      w_rsp_patch;

  logic        o_ready, o_rsp_valid, o_err, o_cyc, o_stb, o_we;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat;
  patch_t      o_rsp_patch;

  int          n_vec, n_bad;
  patch_t      last_rsp;
  logic [31:0] mem [logic [31:0]];
  int          zw [PS];
  int          ws [PS];

  always #5 clk = ~clk;

  wb_patch_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(d_ready), .req_we(req_we),
    .req_addr(req_addr), .req_patch(req_patch),
    .rsp_valid(d_rsp_valid), .rsp_patch(d_rsp_patch), .rsp_err(d_err),
    .wbm_cyc_o(d_cyc), .wbm_stb_o(d_stb), .wbm_we_o(d_we), .wbm_sel_o(d_sel),
    .wbm_adr_o(d_adr), .wbm_dat_o(d_dat), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  wb_patch_master #(.BASE_ADDR(WRAP_BASE), .TIMEOUT_CYCLES(TO)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(w_ready), .req_we(req_we),
    .req_addr(req_addr), .req_patch(req_patch),
    .rsp_valid(w_rsp_valid), .rsp_patch(w_rsp_patch), .rsp_err(w_err),
    .wbm_cyc_o(w_cyc), .wbm_stb_o(w_stb), .wbm_we_o(w_we), .wbm_sel_o(w_sel),
    .wbm_adr_o(w_adr), .wbm_dat_o(w_dat), .wbm_dat_i(dat_i), .wbm_ack_i(ack)
  );

  assign o_ready     = use_wrap ? w_ready     : d_ready;
  assign o_rsp_valid = use_wrap ? w_rsp_valid : d_rsp_valid;
  assign o_err       = use_wrap ? w_err       : d_err;
  assign o_cyc       = use_wrap ? w_cyc       : d_cyc;
  assign o_stb       = use_wrap ? w_stb       : d_stb;
  assign o_we        = use_wrap ? w_we        : d_we;
  assign o_sel       = use_wrap ? w_sel       : d_sel;
  assign o_adr       = use_wrap ? w_adr       : d_adr;
  assign o_dat       = use_wrap ? w_dat       : d_dat;
  assign o_rsp_patch = use_wrap ? w_rsp_patch : d_rsp_patch;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic pulse_reset();
    ack   = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_cyc", o_cyc, 1'b0);
    check("rst_stb", o_stb, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rst_rsp_valid", o_rsp_valid, 1'b0);
    end
    check("rst_ready", o_ready, 1'b1);
    check("rst_patch", o_rsp_patch, '0);
    rst_n    = 1'b1;
    last_rsp = '0;
  endtask

  // One request end to end. waits[k] = wait states before acking beat k;
  // stall_beat never gets acked; abort_beat gets a reset on its first cycle.
  task automatic run_req(input bit we, input logic [8:0] addr, input patch_t patch,
                         input int waits [PS], input int stall_beat, input int abort_beat);
    logic [31:0] base, exp_adr, exp_dat, word;
    patch_t      exp_patch;
    int          beat, hold, cyc, exp_lat;
    bit          done, prev_stb, stalled;
    base      = use_wrap ? WRAP_BASE : MAIN_BASE;
    exp_patch = last_rsp;
    beat = 0; hold = 0; cyc = 0; done = 0; prev_stb = 0; stalled = 0;
    exp_adr = '0; exp_dat = '0;
    exp_lat = 2 * PS + 1;
    for (int i = 0; i < PS; i++) exp_lat += waits[i];
`ifdef WB_TIMEOUT_EN
    if (stall_beat >= 0) begin
      exp_lat = 2 * stall_beat + 1 + TO + 1;
      for (int i = 0; i < stall_beat; i++) exp_lat += waits[i];
    end
`endif
    check("req_ready", o_ready, 1'b1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_patch = patch;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      req_valid = 1'b0;
      ack       = 1'b0;
      dat_i     = $urandom;
      if (o_rsp_valid) begin
        check("rsp_cycle", cyc, exp_lat);
        check("rsp_err", o_err, stalled);
        check("rsp_patch", o_rsp_patch, exp_patch);
        check("ready_at_rsp", o_ready, 1'b1);
        last_rsp = exp_patch;
        done     = 1;
      end else if (o_stb) begin
        if (beat >= PS) begin
          check("beat_count", beat, PS - 1);
          done = 1;
        end else begin
          if (hold == 0) begin
            exp_adr = base + 32'(addr) * 32'(PS) + 32'(beat);
            exp_dat = 32'(patch[beat*DW +: DW]);
            check("gap_before_beat", prev_stb, 1'b0);
            check("adr", o_adr, exp_adr);
            check("we", o_we, we);
            check("sel", o_sel, 4'hF);
            check("cyc", o_cyc, 1'b1);
            if (we) check("dat", o_dat, exp_dat);
          end else begin
            check("adr_hold", o_adr, exp_adr);
            if (we) check("dat_hold", o_dat, exp_dat);
          end
          if (beat == abort_beat) begin
            pulse_reset();
            done = 1;
          end else if (beat == stall_beat) begin
            hold++;
            stalled = 1;
`ifndef WB_TIMEOUT_EN
            if (hold == 3 * TO) begin
              check("stall_stb_held", o_stb, 1'b1);
              pulse_reset();
              done = 1;
            end
`endif
          end else if (hold == waits[beat]) begin
            ack = 1'b1;
            if (we) begin
              mem[o_adr] = o_dat;
            end else begin
              word = mem.exists(o_adr) ? mem[o_adr] : $urandom;
              mem[o_adr] = word;
              dat_i = 32'hFFFFF800 | (word & 32'h7FF);
              exp_patch[beat*DW +: DW] = word[DW-1:0];
            end
            beat++;
            hold = 0;
          end else begin
            hold++;
          end
        end
      end else if (prev_stb && stalled) begin
        check("stall_len", hold, TO);
      end
      prev_stb = o_stb;
    end
    check("req_completed", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    patch_t p;
    patch_t five = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_patch = '0;
    ack = 1'b0; dat_i = '0; use_wrap = 1'b0; last_rsp = '0;
    for (int i = 0; i < PS; i++) zw[i] = 0;

    #12;
    check("reset_cyc", o_cyc, 1'b0);
    check("reset_stb", o_stb, 1'b0);
    check("reset_we", o_we, 1'b0);
    check("reset_sel", o_sel, 4'h0);
    check("reset_adr", o_adr, 32'h0);
    check("reset_dat", o_dat, 32'h0);
    check("reset_rsp_valid", o_rsp_valid, 1'b0);
    check("reset_rsp_err", o_err, 1'b0);
    check("reset_rsp_patch", o_rsp_patch, '0);
    check("reset_ready", o_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single write of element 0 = 1: beats at 557..561, response at cycle 11.
    run_req(1'b1, 9'd9, patch_t'(1), zw, -1, -1);
    // Write {5,4,3,2,1} then read it back through dirty upper data bits.
    run_req(1'b1, 9'd9, five, zw, -1, -1);
    run_req(1'b0, 9'd9, '0, zw, -1, -1);
    check("readback_5_4_3_2_1", o_rsp_patch, five);
    // Three wait states on beat 2.
    ws = zw; ws[2] = 3;
    run_req(1'b0, 9'd9, '0, ws, -1, -1);
    // Reset during beat 3, then a fresh write to patch 0 starts at 512.
    run_req(1'b1, 9'd20, patch_t'({$urandom, $urandom}), zw, -1, 3);
    run_req(1'b1, 9'd0, patch_t'({$urandom, $urandom}), zw, -1, -1);
    // Address wrap around 2^32.
    use_wrap = 1'b1;
    run_req(1'b1, 9'd0, patch_t'({$urandom, $urandom}), zw, -1, -1);
    run_req(1'b0, 9'd0, '0, zw, -1, -1);
    use_wrap = 1'b0;
    // Slave never acks beat 1 of a read.
    run_req(1'b0, 9'd9, '0, zw, 1, -1);

    repeat (40) begin
      p = patch_t'({$urandom, $urandom});
      for (int i = 0; i < PS; i++) ws[i] = $urandom_range(0, 2);
      use_wrap = 1'($urandom_range(0, 1));
      run_req(1'($urandom_range(0, 1)), 9'($urandom_range(0, 7)), p, ws, -1, -1);
    end
    use_wrap = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_patch_master.md
Name: wb_patch_master

Overview:
- Wishbone classic single-beat initiator that loads query patches into, and reads them back from, the query patch memory's Wishbone slave port.
- Each patch transfer is serialized into PATCH_SIZE bus cycles, one element per cycle.
- Sits between the host-side patch loader / debug readback logic and the memory's wbs_* port.
- Replaces hand-driven bus stimulus with a cycle-accurate master.

Parameters:
- DATA_WIDTH, 11: bits per patch element.
- PATCH_SIZE, 5: elements per patch.
- ADDR_WIDTH, 9: patch index width.
- BASE_ADDR, 32'h200: Wishbone byte-agnostic word address of patch 0, element 0.
- TIMEOUT_CYCLES, 64: ack watchdog limit. Used only with WB_TIMEOUT_EN.

Ports:
- clk  input  1  single clock; bus and request side share it.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = write patch, 0 = read patch.
- req_addr  input  ADDR_WIDTH  patch index.
- req_patch  input  DATA_WIDTH*PATCH_SIZE  write data; element 0 in LSBs.
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_patch  output  DATA_WIDTH*PATCH_SIZE  assembled read data; holds its value until the next read completes.
- rsp_err  output  1  valid with rsp_valid; 1 = aborted by timeout.
- wbm_cyc_o  output  1  bus cycle.
- wbm_stb_o  output  1  strobe.
- wbm_we_o  output  1  write enable.
- wbm_sel_o  output  4  byte selects; always 4'hF while stb is high.
- wbm_adr_o  output  32  word address.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  slave acknowledge.

Behaviour:
- Reset (async, rst_n low):
  - FSM goes to IDLE immediately.
  - wbm_cyc_o, wbm_stb_o, wbm_we_o, rsp_valid and rsp_err are all 0.
  - wbm_sel_o, wbm_adr_o, wbm_dat_o and rsp_patch are all 0.
  - Element index and watchdog counter are 0.
  - Reset mid-transfer drops cyc/stb at once; no rsp_valid is produced for the aborted request.
- FSM states: IDLE -> ISSUE -> GAP -> ISSUE ... -> RESP -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid, latch we/addr/patch and set idx=0.
  - Next cycle enter ISSUE.
- ISSUE:
  - All bus outputs are registered.
  - cyc=stb=1, we=latched we.
  - adr = BASE_ADDR + addr*PATCH_SIZE + idx, computed at 32 bits, unsigned, wraps mod 2^32.
  - dat_o = zero-extended element idx.
  - Outputs stay stable until wbm_ack_i is sampled high.
  - On ack during a read, capture wbm_dat_i[DATA_WIDTH-1:0] into element idx of rsp_patch; upper bits are ignored.
  - On ack, if idx==PATCH_SIZE-1 go to RESP, else go to GAP.
- GAP:
  - One cycle with cyc=stb=0 between beats; idx++.
  - Then return to ISSUE.
- RESP:
  - cyc=stb=0, rsp_valid=1 for exactly one cycle, rsp_err=0.
  - Then IDLE.
- Latency with zero-wait-state ack: accept at cycle 0, first stb at cycle 1, rsp_valid at cycle 2*PATCH_SIZE+1.
- wbm_ack_i outside ISSUE is ignored.
- req_valid outside IDLE is not accepted; the requester holds it.
- Back-to-back requests: the next accept can occur in the IDLE cycle after RESP.

Optional Feature:
- Macro: WB_TIMEOUT_EN.
- With the macro defined:
  - The watchdog counter clears on ISSUE entry and increments each ISSUE cycle without ack.
  - When it reaches TIMEOUT_CYCLES, cyc/stb drop the next cycle, the remaining beats are skipped, and the FSM goes to RESP with rsp_err=1.
  - rsp_patch keeps the elements captured so far.
- Without the macro: no counter is built, rsp_err is tied 0, and ISSUE waits for ack indefinitely.

Decomposition:
- Package patch_pkg holds:
  - default DATA_WIDTH/PATCH_SIZE/ADDR_WIDTH/BASE_ADDR constants;
  - the patch vector typedef;
  - the FSM state enum {IDLE, ISSUE, GAP, RESP}.
- One sub-module, wb_patch_addr_gen: combinational BASE_ADDR + addr*PATCH_SIZE + idx, registered by the parent.

Test Plan:
- Write, req_addr=9, patch={44'b0,11'd1}, zero-wait slave:
  - 5 beats at adr 557..561, dat 1,0,0,0,0, we=1;
  - rsp_valid at cycle 11, rsp_err=0.
- Read back patch 9 after writing elements {5,4,3,2,1} (element 0 = 1):
  - rsp_patch = {11'd5,11'd4,11'd3,11'd2,11'd1};
  - slave returns 0xFFFFF800|value on the upper bits, which are ignored.
- Slave inserts 3 wait states on beat 2:
  - adr/dat/stb held constant for 4 cycles;
  - total latency 14 cycles; the GAP cycle is always present between beats.
- Reset asserted during beat 3:
  - cyc/stb go 0 asynchronously, no rsp_valid;
  - after release, req_ready=1 and a new write to addr 0 starts at adr 512.
- Address wrap: BASE_ADDR=32'hFFFFFFFE, req_addr=0:
  - adr sequence FFFFFFFE, FFFFFFFF, 0, 1, 2.
- WB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never acks beat 1:
  - stb high for 8 cycles then drops;
  - rsp_valid with rsp_err=1, only beat 0 data captured.
  - Without the macro, the same stimulus leaves stb high indefinitely.
